// File: rtl/tspi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tspi_pkg                                                             |
// | Shared Tri-SPI frame geometry and link FSM states (rx and tx).       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package tspi_pkg;
    localparam int ROW_PIX = 6;
    localparam int ROWS    = 39;
    localparam int NPIX    = ROWS * ROW_PIX;
    localparam int NGRID   = 52;
    localparam int NBITS   = 288;

    typedef enum logic [0:0] {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage
`default_nettype wire

// File: rtl/tspi_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tspi_sync_edge                                                       |
// | Multi-stage input synchronizer; edge lanes also get a rise pulse.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tspi_sync_edge #(
    parameter int STAGES = 2,
    parameter int EDGES  = 2,
    parameter int LEVELS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [EDGES-1:0]  edge_d,
    input  logic [LEVELS-1:0] lvl_d,
    output logic [EDGES-1:0]  rise,
    output logic [LEVELS-1:0] lvl_q
);
    // Both chains share one depth so level lanes stay aligned with the edges.
    logic [STAGES-1:0][EDGES-1:0]  r_edge;
    logic [STAGES-1:0][LEVELS-1:0] r_lvl;
    logic [EDGES-1:0]              r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge <= '0;
            r_lvl  <= '0;
            r_prev <= '0;
        end else begin
            r_edge <= {r_edge[STAGES-2:0], edge_d};
            r_lvl  <= {r_lvl[STAGES-2:0], lvl_d};
            r_prev <= r_edge[STAGES-1];
        end
    end

    assign rise  = r_edge[STAGES-1] & ~r_prev;
    assign lvl_q = r_lvl[STAGES-1];
endmodule
`default_nettype wire

// File: rtl/tspi_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tspi_rx                                                              |
// | Tri-SPI VFD link receiver: pixel writes, grid decode, frame status.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tspi_rx
    import tspi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       sin1,
    input  logic       sin2,
    input  logic       sin3,
    input  logic       lat,
    input  logic       blk,
    output logic       pix_we,
    output logic [5:0] pix_row,
    output logic [2:0] pix_col,
    output logic [2:0] pix_val,
    output logic       frame_done,
    output logic [5:0] grid_n,
    output logic       grid_ok,
    output logic       cnt_err,
    output logic       blanked
);
    localparam logic [8:0] c_NPIX     = 9'(NPIX);
    localparam logic [8:0] c_GRID_END = 9'(NPIX + NGRID);
    localparam logic [8:0] c_NBITS    = 9'(NBITS);
    localparam logic [2:0] c_COL_LAST = 3'(ROW_PIX - 1);

    logic [1:0] w_rise;
    logic [3:0] w_lvl;
    logic       w_sck_rise, w_lat_rise, w_blk;
    logic [2:0] w_lanes;

    tspi_sync_edge #(
        .STAGES (SYNC_STAGES),
        .EDGES  (2),
        .LEVELS (4)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .edge_d ({lat, sck}),
        .lvl_d  ({blk, sin3, sin2, sin1}),
        .rise   (w_rise),
        .lvl_q  (w_lvl)
    );

    assign w_sck_rise = w_rise[0];
    assign w_lat_rise = w_rise[1];
    assign w_lanes    = w_lvl[2:0];
    assign w_blk      = w_lvl[3];

    state_t     r_state;
    logic [8:0] r_slot;
    logic [5:0] r_row, r_first, r_last;
    logic [2:0] r_col;
    logic [1:0] r_cnt;
    logic       r_mis;

    logic       w_take, w_is_pix, w_is_grid;
    logic [5:0] w_gidx;
    logic [8:0] w_slot_nx;
    logic [5:0] w_row_nx, w_first_nx, w_last_nx;
    logic [2:0] w_col_nx;
    logic [1:0] w_cnt_nx;
    logic       w_mis_nx;

    // Tracker state after this cycle's slot, so a coincident latch sees it.
    always_comb begin
        w_take     = (r_state == RUN) && w_sck_rise;
        w_is_pix   = r_slot < c_NPIX;
        w_is_grid  = !w_is_pix && (r_slot < c_GRID_END);
        w_gidx     = 6'(r_slot - c_NPIX);
        w_slot_nx  = r_slot;
        w_row_nx   = r_row;
        w_col_nx   = r_col;
        w_cnt_nx   = r_cnt;
        w_first_nx = r_first;
        w_last_nx  = r_last;
        w_mis_nx   = r_mis;
        if (w_take) begin
            if (r_slot != 9'h1FF) begin
                w_slot_nx = r_slot + 9'd1;
            end
            if (w_is_pix) begin
                if (r_col == c_COL_LAST) begin
                    w_col_nx = 3'd0;
                    w_row_nx = r_row + 6'd1;
                end else begin
                    w_col_nx = r_col + 3'd1;
                end
            end else if (w_is_grid) begin
                if (&w_lanes) begin
                    if (r_cnt == 2'd0) begin
                        w_first_nx = w_gidx;
                    end
                    w_last_nx = w_gidx;
                    if (r_cnt != 2'd3) begin
                        w_cnt_nx = r_cnt + 2'd1;
                    end
                end else if (|w_lanes) begin
                    w_mis_nx = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SYNC;
            r_slot     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_cnt      <= '0;
            r_first    <= '0;
            r_last     <= '0;
            r_mis      <= 1'b0;
            pix_we     <= 1'b0;
            pix_row    <= '0;
            pix_col    <= '0;
            pix_val    <= '0;
            frame_done <= 1'b0;
            grid_n     <= '0;
            grid_ok    <= 1'b0;
            cnt_err    <= 1'b0;
            blanked    <= 1'b0;
        end else begin
            pix_we     <= 1'b0;
            frame_done <= 1'b0;
            if (w_take && w_is_pix) begin
                pix_we  <= 1'b1;
                pix_row <= r_row;
                pix_col <= r_col;
                pix_val <= w_lanes;
            end
            if (w_lat_rise) begin
                if (r_state == RUN) begin
                    frame_done <= 1'b1;
                    grid_ok    <= (w_cnt_nx == 2'd2) && (w_last_nx == w_first_nx + 6'd1) && !w_mis_nx;
                    grid_n     <= w_first_nx;
                    cnt_err    <= (w_slot_nx != c_NBITS);
                    blanked    <= w_blk;
                end
                r_state <= RUN;
                r_slot  <= '0;
                r_row   <= '0;
                r_col   <= '0;
                r_cnt   <= '0;
                r_first <= '0;
                r_last  <= '0;
                r_mis   <= 1'b0;
            end else begin
                r_slot  <= w_slot_nx;
                r_row   <= w_row_nx;
                r_col   <= w_col_nx;
                r_cnt   <= w_cnt_nx;
                r_first <= w_first_nx;
                r_last  <= w_last_nx;
                r_mis   <= w_mis_nx;
            end
        end
    end
endmodule
`default_nettype wire
